alu_stack: RTL and testbench

Operand-stack front end for the combinational ALU: holds a LIFO of WIDTH-bit values and, on each ALU command, drives the ALU operation and operands from the top of stack, then replaces them with the ALU result on the same clock edge. It is the issuing side of the ALU interface (`op`/`arg0`/`arg1` out, `data` in) and sits between the instruction sequencer and the ALU in the CSM datapath. All commands complete in one cycle; illegal commands are dropped and flagged.

---
 rtl/alu_stack.sv | 159 +++++++++++++++
 tb/tb_alu_stack.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_stack.sv
// alu_stack: operand-stack front end for a combinational ALU.
//
// This block holds a LIFO of WIDTH-bit values. On an ALU command it drives the
// ALU operation and operands from the top of the stack. On the same clock edge
// it replaces those operands with the ALU result.
//
// Ports:
//   i_clk, i_rst     clock; synchronous active-high reset
//   i_valid          command strobe
//   i_cmd            0=NOP, 1=PUSH, 2=ALU1 (unary), 3=ALU2 (binary)
//   i_op             ALU operation code, passed through on ALU1/ALU2
//   i_data           value pushed on PUSH
//   o_op             operation presented to the ALU (0 when not issuing)
//   o_arg0, o_arg1   ALU operands
//   i_result         combinational result returned by the ALU
//   o_tos            top-of-stack value (0 when empty)
//   o_depth          current element count
//   o_empty, o_full  depth == 0 / depth == DEPTH
//   o_err            sticky overflow/underflow flag, cleared only by reset
module alu_stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_valid,
  input  logic [1:0]                 i_cmd,
  input  logic [3:0]                 i_op,
  input  logic [WIDTH-1:0]           i_data,
  output logic [3:0]                 o_op,
  output logic [WIDTH-1:0]           o_arg0,
  output logic [WIDTH-1:0]           o_arg1,
  input  logic [WIDTH-1:0]           i_result,
  output logic [WIDTH-1:0]           o_tos,
  output logic [$clog2(DEPTH):0]     o_depth,
  output logic                       o_empty,
  output logic                       o_full,
  output logic                       o_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int DW = AW + 1;

  localparam logic [1:0] CMD_NOP  = 2'd0;
  localparam logic [1:0] CMD_PUSH = 2'd1;
  localparam logic [1:0] CMD_ALU1 = 2'd2;
  localparam logic [1:0] CMD_ALU2 = 2'd3;

  logic [WIDTH-1:0] stack_mem [DEPTH];
  logic [DW-1:0]    depth;
  logic             err;

  logic [AW-1:0]    tos_idx;
  logic [AW-1:0]    nos_idx;
  logic [WIDTH-1:0] tos_val;
  logic [WIDTH-1:0] nos_val;

  logic             push_ok;
  logic             alu1_ok;
  logic             alu2_ok;
  logic             wr_en;
  logic [AW-1:0]    wr_idx;
  logic [WIDTH-1:0] wr_data;
  logic [DW-1:0]    depth_nxt;
  logic             err_nxt;

  // The indices use modular arithmetic on the low AW bits. When depth == DEPTH,
  // the low bits are 0, and 0 - 1 wraps to DEPTH-1, which is the correct TOS.
  assign tos_idx = depth[AW-1:0] - AW'(1);
  assign nos_idx = depth[AW-1:0] - AW'(2);

  // Contents of unused slots are never exposed: an empty stack reads as 0.
  assign tos_val = (depth >= DW'(1)) ? stack_mem[tos_idx] : '0;
  assign nos_val = (depth >= DW'(2)) ? stack_mem[nos_idx] : '0;

  assign push_ok = (depth < DW'(DEPTH));
  assign alu1_ok = (depth >= DW'(1));
  assign alu2_ok = (depth >= DW'(2));

  // ALU drive: combinational from the current state and the inputs.
  always_comb begin
    o_op   = 4'd0;
    o_arg0 = tos_val;
    o_arg1 = '0;
    if (i_valid && i_cmd == CMD_ALU1) begin
      o_op = i_op;
    end else if (i_valid && i_cmd == CMD_ALU2) begin
      o_op   = i_op;
      o_arg0 = nos_val;
      o_arg1 = tos_val;
    end
  end

  // Command decode: illegal commands leave the stack untouched and raise err.
  always_comb begin
    wr_en     = 1'b0;
    wr_idx    = tos_idx;
    wr_data   = i_result;
    depth_nxt = depth;
    err_nxt   = err;
    if (i_valid) begin
      unique case (i_cmd)
        CMD_NOP: ;
        CMD_PUSH: begin
          if (push_ok) begin
            wr_en     = 1'b1;
            wr_idx    = depth[AW-1:0];
            wr_data   = i_data;
            depth_nxt = depth + DW'(1);
          end else begin
            err_nxt = 1'b1;
          end
        end
        CMD_ALU1: begin
          if (alu1_ok) begin
            wr_en = 1'b1;
          end else begin
            err_nxt = 1'b1;
          end
        end
        CMD_ALU2: begin
          if (alu2_ok) begin
            wr_en     = 1'b1;
            wr_idx    = nos_idx;
            depth_nxt = depth - DW'(1);
          end else begin
            err_nxt = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // State boundary: control registers (reset) and storage (not reset).
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      depth <= '0;
      err   <= 1'b0;
    end else begin
      depth <= depth_nxt;
      err   <= err_nxt;
    end
  end

  // Reset discards a command issued in the same cycle, so it also gates the write.
  always_ff @(posedge i_clk) begin
    if (wr_en && !i_rst) begin
      stack_mem[wr_idx] <= wr_data;
    end
  end

  assign o_tos   = tos_val;
  assign o_depth = depth;
  assign o_empty = (depth == '0);
  assign o_full  = (depth == DW'(DEPTH));
  assign o_err   = err;

endmodule

// File: tb/tb_alu_stack.sv
// Testbench for alu_stack. The bench holds a small stand-in ALU that returns
// i_result combinationally. Its codes are ADD=1, SUB=2 and ROL=3.
module tb_alu_stack;

  localparam int WIDTH = 8;
  localparam int DEPTH = 8;

  localparam logic [1:0] NOP  = 2'd0;
  localparam logic [1:0] PUSH = 2'd1;
  localparam logic [1:0] ALU1 = 2'd2;
  localparam logic [1:0] ALU2 = 2'd3;

  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_ROL = 4'd3;

  logic             clk;
  logic             rst;
  logic             valid;
  logic [1:0]       cmd;
  logic [3:0]       op_in;
  logic [WIDTH-1:0] data_in;
  logic [3:0]       op_out;
  logic [WIDTH-1:0] arg0;
  logic [WIDTH-1:0] arg1;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] tos;
  logic [3:0]       depth;
  logic             empty;
  logic             full;
  logic             err;

  int n_total = 0;
  int n_pass  = 0;

  alu_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_valid (valid),
    .i_cmd   (cmd),
    .i_op    (op_in),
    .i_data  (data_in),
    .o_op    (op_out),
    .o_arg0  (arg0),
    .o_arg1  (arg1),
    .i_result(result),
    .o_tos   (tos),
    .o_depth (depth),
    .o_empty (empty),
    .o_full  (full),
    .o_err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in combinational ALU.
  always_comb begin
    result = '0;
    case (op_out)
      OP_ADD:  result = arg0 + arg1;
      OP_SUB:  result = arg0 - arg1;
      OP_ROL:  result = {arg0[WIDTH-2:0], arg0[WIDTH-1]};
      default: result = '0;
    endcase
  end

  // Present a command at the falling edge and let the combinational outputs settle.
  task automatic drive(input logic v, input logic [1:0] c, input logic [3:0] o,
                       input logic [WIDTH-1:0] d);
    @(negedge clk);
    valid   = v;
    cmd     = c;
    op_in   = o;
    data_in = d;
    #1;
  endtask

  // Let the command take effect, then release the strobe.
  task automatic tick();
    @(posedge clk);
    #1;
    valid = 1'b0;
    cmd   = NOP;
    op_in = 4'd0;
  endtask

  task automatic issue(input logic [1:0] c, input logic [3:0] o, input logic [WIDTH-1:0] d);
    drive(1'b1, c, o, d);
    tick();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst   = 1'b1;
    valid = 1'b0;
    cmd   = NOP;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_total++; if (depth !== 4'd0) $display("FAIL reset_depth got=%0d exp=0", depth); else n_pass++;
    n_total++; if (empty !== 1'b1) $display("FAIL reset_empty got=%0b exp=1", empty); else n_pass++;
    n_total++; if (full !== 1'b0) $display("FAIL reset_full got=%0b exp=0", full); else n_pass++;
    n_total++; if (err !== 1'b0) $display("FAIL reset_err got=%0b exp=0", err); else n_pass++;
    n_total++; if (tos !== 8'h00) $display("FAIL reset_tos got=%h exp=00", tos); else n_pass++;
    n_total++; if (op_out !== 4'd0) $display("FAIL reset_op got=%0d exp=0", op_out); else n_pass++;
    n_total++; if (arg0 !== 8'h00 || arg1 !== 8'h00)
      $display("FAIL reset_args got=%h/%h exp=00/00", arg0, arg1); else n_pass++;
  endtask

  task automatic test_add();
    do_reset();
    issue(PUSH, 4'd0, 8'h05);
    issue(PUSH, 4'd0, 8'h03);
    drive(1'b1, ALU2, OP_ADD, 8'h00);
    n_total++; if (op_out !== OP_ADD) $display("FAIL add_op got=%0d exp=1", op_out); else n_pass++;
    n_total++; if (arg0 !== 8'h05) $display("FAIL add_arg0 got=%h exp=05", arg0); else n_pass++;
    n_total++; if (arg1 !== 8'h03) $display("FAIL add_arg1 got=%h exp=03", arg1); else n_pass++;
    tick();
    n_total++; if (tos !== 8'h08) $display("FAIL add_tos got=%h exp=08", tos); else n_pass++;
    n_total++; if (depth !== 4'd1) $display("FAIL add_depth got=%0d exp=1", depth); else n_pass++;
  endtask

  task automatic test_sub_wrap();
    do_reset();
    issue(PUSH, 4'd0, 8'h05);
    issue(PUSH, 4'd0, 8'h07);
    issue(ALU2, OP_SUB, 8'h00);
    n_total++; if (tos !== 8'hFE) $display("FAIL sub_tos got=%h exp=fe", tos); else n_pass++;
    n_total++; if (depth !== 4'd1) $display("FAIL sub_depth got=%0d exp=1", depth); else n_pass++;
    n_total++; if (err !== 1'b0) $display("FAIL sub_err got=%0b exp=0", err); else n_pass++;
  endtask

  task automatic test_unary();
    do_reset();
    issue(PUSH, 4'd0, 8'h81);
    drive(1'b1, ALU1, OP_ROL, 8'h00);
    n_total++; if (arg0 !== 8'h81) $display("FAIL rol_arg0 got=%h exp=81", arg0); else n_pass++;
    n_total++; if (arg1 !== 8'h00) $display("FAIL rol_arg1 got=%h exp=00", arg1); else n_pass++;
    tick();
    n_total++; if (tos !== 8'h03) $display("FAIL rol_tos got=%h exp=03", tos); else n_pass++;
    n_total++; if (depth !== 4'd1) $display("FAIL rol_depth got=%0d exp=1", depth); else n_pass++;
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 1; i <= 8; i++) issue(PUSH, 4'd0, 8'(i));
    n_total++; if (full !== 1'b1) $display("FAIL full_flag got=%0b exp=1", full); else n_pass++;
    n_total++; if (tos !== 8'h08) $display("FAIL full_tos got=%h exp=08", tos); else n_pass++;
    n_total++; if (depth !== 4'd8) $display("FAIL full_depth got=%0d exp=8", depth); else n_pass++;
    issue(PUSH, 4'd0, 8'hAA);
    n_total++; if (err !== 1'b1) $display("FAIL ovf_err got=%0b exp=1", err); else n_pass++;
    n_total++; if (tos !== 8'h08) $display("FAIL ovf_tos got=%h exp=08", tos); else n_pass++;
    n_total++; if (depth !== 4'd8) $display("FAIL ovf_depth got=%0d exp=8", depth); else n_pass++;
    issue(ALU2, OP_ADD, 8'h00);
    n_total++; if (tos !== 8'h0F) $display("FAIL ovf_add_tos got=%h exp=0f", tos); else n_pass++;
    n_total++; if (depth !== 4'd7) $display("FAIL ovf_add_depth got=%0d exp=7", depth); else n_pass++;
    n_total++; if (err !== 1'b1) $display("FAIL ovf_sticky got=%0b exp=1", err); else n_pass++;
    n_total++; if (full !== 1'b0) $display("FAIL ovf_full got=%0b exp=0", full); else n_pass++;
  endtask

  task automatic test_underflow();
    do_reset();
    issue(ALU2, OP_ADD, 8'h00);
    n_total++; if (err !== 1'b1) $display("FAIL unf_empty_err got=%0b exp=1", err); else n_pass++;
    n_total++; if (depth !== 4'd0) $display("FAIL unf_empty_depth got=%0d exp=0", depth); else n_pass++;
    do_reset();
    issue(ALU1, OP_ROL, 8'h00);
    n_total++; if (err !== 1'b1) $display("FAIL unf_alu1_err got=%0b exp=1", err); else n_pass++;
    n_total++; if (empty !== 1'b1) $display("FAIL unf_alu1_empty got=%0b exp=1", empty); else n_pass++;
    do_reset();
    issue(PUSH, 4'd0, 8'h01);
    issue(ALU2, OP_ADD, 8'h00);
    n_total++; if (err !== 1'b1) $display("FAIL unf_one_err got=%0b exp=1", err); else n_pass++;
    n_total++; if (depth !== 4'd1) $display("FAIL unf_one_depth got=%0d exp=1", depth); else n_pass++;
    n_total++; if (tos !== 8'h01) $display("FAIL unf_one_tos got=%h exp=01", tos); else n_pass++;
  endtask

  task automatic test_reset_priority();
    do_reset();
    issue(ALU1, OP_ROL, 8'h00);
    issue(PUSH, 4'd0, 8'h11);
    issue(PUSH, 4'd0, 8'h22);
    n_total++; if (err !== 1'b1) $display("FAIL rstp_pre_err got=%0b exp=1", err); else n_pass++;
    @(negedge clk);
    rst     = 1'b1;
    valid   = 1'b1;
    cmd     = PUSH;
    data_in = 8'h33;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    valid = 1'b0;
    cmd   = NOP;
    n_total++; if (depth !== 4'd0) $display("FAIL rstp_depth got=%0d exp=0", depth); else n_pass++;
    n_total++; if (empty !== 1'b1) $display("FAIL rstp_empty got=%0b exp=1", empty); else n_pass++;
    n_total++; if (tos !== 8'h00) $display("FAIL rstp_tos got=%h exp=00", tos); else n_pass++;
    n_total++; if (err !== 1'b0) $display("FAIL rstp_err got=%0b exp=0", err); else n_pass++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    issue(PUSH, 4'd0, 8'h0A);
    issue(PUSH, 4'd0, 8'h14);
    issue(PUSH, 4'd0, 8'h1E);
    drive(1'b0, PUSH, 4'd0, 8'h99);
    tick();
    n_total++; if (depth !== 4'd3) $display("FAIL b2b_novalid_depth got=%0d exp=3", depth); else n_pass++;
    issue(NOP, OP_ADD, 8'h77);
    n_total++; if (tos !== 8'h1E) $display("FAIL b2b_nop_tos got=%h exp=1e", tos); else n_pass++;
    issue(ALU2, OP_ADD, 8'h00);
    n_total++; if (tos !== 8'h32) $display("FAIL b2b_add_tos got=%h exp=32", tos); else n_pass++;
    issue(ALU2, OP_SUB, 8'h00);
    n_total++; if (tos !== 8'hD8) $display("FAIL b2b_sub_tos got=%h exp=d8", tos); else n_pass++;
    n_total++; if (depth !== 4'd1) $display("FAIL b2b_depth got=%0d exp=1", depth); else n_pass++;
    n_total++; if (err !== 1'b0) $display("FAIL b2b_err got=%0b exp=0", err); else n_pass++;
  endtask

  initial begin
    rst     = 1'b1;
    valid   = 1'b0;
    cmd     = NOP;
    op_in   = 4'd0;
    data_in = '0;
    test_reset();
    test_add();
    test_sub_wrap();
    test_unary();
    test_overflow();
    test_underflow();
    test_reset_priority();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
